sample_buffer: RTL and testbench
================================

Name: sample_buffer

Overview:
Producer side of the averager handshake. It packs a stream of 8-bit samples into 32-bit words, four samples per word. It presents each word on buffer_data with find_average and full_buffer_flag, and holds it until average_done returns. Double-buffered: a fill register collects the next word while the presented word waits, so the sample stream is not stalled during a calculation.

Parameters:
DONE_TIMEOUT, 255, max cycles a word is presented without average_done before it is abandonned (range 1..65535).

Ports:
clk_2  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
sample_data  in  8  incoming sample byte
sample_valid  in  1  sample_data is valid this cycle; accepted unconditionally
average_done  in  1  averager has consumed the presented word
clear_flags  in  1  clears overrun and timeout_err
buffer_data  out  32  presented word; first sample in [7:0], fourth in [31:24]
find_average  out  1  request to averager; high while a word is presented
full_buffer_flag  out  1  buffer_data holds a complete word; equal to find_average
overrun  out  1  sticky: a sample was dropped
timeout_err  out  1  sticky: a word was abandoned after DONE_TIMEOUT
words_sent  out  16  count of words acknowledged by average_done, wraps at 0xFFFF->0

Behaviour:
Reset (synchronous, sampled on clk_2 rising edge while reset=1):
- All outputs 0, buffer_data=0, fill count=0, slot state EMPTY, timeout counter=0.
- Reset mid-handshake discards both fill and slot contents. No partial word survives.

Fill side (2-bit count, 32-bit fill register):
- sample_valid with count<4: byte written to lane [count], count+1.
- If the byte completes the word (count 3->4) and the slot is EMPTY, the word moves straight to the slot on that same edge, and count becomes 0.
- If count==4 (fill full, waiting for the slot) and sample_valid=1: the sample is dropped and overrun<=1. Fill is unchanged.

Slot state machine (states EMPTY, PRESENT, RELEASE):
- EMPTY -> PRESENT when a complete word is transferred in, either from the direct path or from a held full fill. find_average=full_buffer_flag=1 from the cycle after the transfer edge.
- PRESENT: buffer_data is stable and the timeout counter increments each cycle.
  - average_done=1 -> RELEASE, words_sent+1.
  - Counter reaches DONE_TIMEOUT with no done -> RELEASE, timeout_err<=1, word discarded, words_sent unchanged.
- RELEASE: exactly one cycle with find_average=full_buffer_flag=0, so the averager returns to IDLE. Counter cleared. Then:
  - If fill is full, transfer and go to PRESENT.
  - Else go to EMPTY.
- A transfer out of a held full fill on the same edge as a new sample_valid: the fill empties and the new byte lands in lane 0, count=1. No drop.
- average_done outside PRESENT is ignored.

Latency and timing:
- Latency from the 4th sample edge to find_average high is 1 cycle when the slot is EMPTY.
- Minimum word-to-word spacing is PRESENT(≥1) + RELEASE(1) cycles.

Flags:
- clear_flags=1 clears overrun and timeout_err.
- If clear_flags and a new set event occur in the same cycle, the set wins.

Decomposition:
- Package sample_buffer_pkg: slot_state_t enum {EMPTY, PRESENT, RELEASE}; constants BYTE_W=8, BYTES_PER_WORD=4, WORD_W=32.
- Sub-module byte_packer: fill register, count, fill_full, overrun detect. It takes a take_word strobe from the slot FSM.
- Top level holds the slot FSM, timeout counter and words_sent.

Test Plan:
- Samples 0x10,0x20,0x30,0x40 back-to-back, averager model returns done 1 cycle after find_average -> buffer_data=0x40302010, find_average high 1 cycle after 4th sample, one RELEASE cycle low, words_sent=1; real averager yields average_result=0x28.
- 8 back-to-back samples 0x01..0x08, done delayed 10 cycles -> second word 0x08070605 held in fill, presented right after RELEASE, no overrun, words_sent=2.
- 9 back-to-back samples with done withheld -> 9th sample dropped, overrun=1; clear_flags then clears it.
- DONE_TIMEOUT=5, no done -> timeout_err=1 after 5 PRESENT cycles, find_average falls, words_sent=0, slot EMPTY.
- Reset asserted mid-PRESENT with 2 bytes in fill -> next cycle all outputs 0; then 4 new samples 0xAA,0xBB,0xCC,0xDD -> buffer_data=0xDDCCBBAA.
- average_done pulsed while EMPTY -> no state change, words_sent unchanged.

Source files
------------

// File: rtl/sample_buffer_pkg.sv
// Shared types and widths for the sample_buffer producer, which packs bytes into
// words for the averager.
package sample_buffer_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    EMPTY,
    PRESENT,
    RELEASE
  } slot_state_t;

endpackage

// File: rtl/sample_buffer_byte_packer.sv
// Fill side: collects four bytes into a word and holds a full word until the slot
// takes it.
module byte_packer
  import sample_buffer_pkg::*;
(
  input  logic              clk_2,
  input  logic              reset,
  input  logic [BYTE_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic              direct_ok,
  input  logic              take_word,
  output logic [WORD_W-1:0] fill_word,
  output logic [WORD_W-1:0] complete_word,
  output logic              direct_word,
  output logic              fill_full,
  output logic              drop
);

  logic [WORD_W-1:0] fill_q;
  logic [1:0]        count_q;
  logic              full_q;
  logic              complete_now;

  always_comb begin
    complete_now  = sample_valid && !full_q && (count_q == 2'd3);
    complete_word = {sample_data, fill_q[3*BYTE_W-1:0]};
    direct_word   = complete_now && direct_ok;
    drop          = sample_valid && full_q && !take_word;
    fill_word     = fill_q;
    fill_full     = full_q;
  end

  // A full fill is encoded as full_q with count_q back at 0.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      fill_q  <= '0;
      count_q <= 2'd0;
      full_q  <= 1'b0;
    end else if (take_word) begin
      full_q <= 1'b0;
      if (sample_valid) begin
        fill_q[BYTE_W-1:0] <= sample_data;
        count_q            <= 2'd1;
      end else begin
        count_q <= 2'd0;
      end
    end else if (sample_valid && !full_q) begin
      unique case (count_q)
        2'd0: fill_q[1*BYTE_W-1:0*BYTE_W] <= sample_data;
        2'd1: fill_q[2*BYTE_W-1:1*BYTE_W] <= sample_data;
        2'd2: fill_q[3*BYTE_W-1:2*BYTE_W] <= sample_data;
        2'd3: fill_q[4*BYTE_W-1:3*BYTE_W] <= sample_data;
        default: ;
      endcase
      count_q <= count_q + 2'd1;
      if (complete_now && !direct_ok) begin
        full_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_buffer.sv
// Producer side of the averager handshake: double-buffered byte-to-word packing
// with a presented slot, done timeout, sticky error flags and an acknowledge count.
module sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic [BYTE_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic              average_done,
  input  logic              clear_flags,
  output logic [WORD_W-1:0] buffer_data,
  output logic              find_average,
  output logic              full_buffer_flag,
  output logic              overrun,
  output logic              timeout_err,
  output logic [15:0]       words_sent
);

  localparam logic [15:0] TmoLast = 16'(DONE_TIMEOUT - 1);

  slot_state_t       state_q;
  logic [WORD_W-1:0] buf_q;
  logic [15:0]       tmo_q;
  logic [15:0]       sent_q;
  logic              overrun_q;
  logic              timeout_q;

  logic [WORD_W-1:0] fill_word;
  logic [WORD_W-1:0] complete_word;
  logic              direct_word;
  logic              fill_full;
  logic              drop;
  logic              take_word;
  logic              direct_ok;
  logic              tmo_expire;

  always_comb begin
    direct_ok  = (state_q == EMPTY);
    take_word  = fill_full && ((state_q == EMPTY) || (state_q == RELEASE));
    tmo_expire = (state_q == PRESENT) && !average_done && (tmo_q == TmoLast);
  end

  byte_packer u_byte_packer (
    .clk_2         (clk_2),
    .reset         (reset),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .direct_ok     (direct_ok),
    .take_word     (take_word),
    .fill_word     (fill_word),
    .complete_word (complete_word),
    .direct_word   (direct_word),
    .fill_full     (fill_full),
    .drop          (drop)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q   <= EMPTY;
      buf_q     <= '0;
      tmo_q     <= '0;
      sent_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (direct_word) begin
            buf_q   <= complete_word;
            state_q <= PRESENT;
          end else if (fill_full) begin
            buf_q   <= fill_word;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (average_done) begin
            sent_q  <= sent_q + 16'd1;
            state_q <= RELEASE;
          end else if (tmo_expire) begin
            state_q <= RELEASE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        RELEASE: begin
          tmo_q <= '0;
          if (fill_full) begin
            buf_q   <= fill_word;
            state_q <= PRESENT;
          end else begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase

      // A set event in the same cycle as clear_flags wins.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clear_flags) begin
        overrun_q <= 1'b0;
      end
      if (tmo_expire) begin
        timeout_q <= 1'b1;
      end else if (clear_flags) begin
        timeout_q <= 1'b0;
      end
    end
  end

  always_comb begin
    buffer_data      = buf_q;
    find_average     = (state_q == PRESENT);
    full_buffer_flag = (state_q == PRESENT);
    overrun          = overrun_q;
    timeout_err      = timeout_q;
    words_sent       = sent_q;
  end

endmodule

// File: tb/tb_sample_buffer.sv
// Directed and randomized bench for sample_buffer against a queue-based reference model.
module tb_sample_buffer;

  localparam int unsigned Tmo = 12;

  logic        clk_2 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        average_done = 1'b0;
  logic        clear_flags = 1'b0;
  logic [31:0] buffer_data;
  logic        find_average;
  logic        full_buffer_flag;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] words_sent;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: a byte queue for the fill, plus the presented word and its age.
  logic [7:0]  m_fill[$];
  logic        m_pres = 1'b0;
  logic        m_rel  = 1'b0;
  logic [31:0] m_word = '0;
  int          m_age  = 0;
  logic [15:0] m_sent = '0;
  logic        m_ovr  = 1'b0;
  logic        m_tmo  = 1'b0;

  sample_buffer #(.DONE_TIMEOUT(Tmo)) dut (
    .clk_2            (clk_2),
    .reset            (reset),
    .sample_data      (sample_data),
    .sample_valid     (sample_valid),
    .average_done     (average_done),
    .clear_flags      (clear_flags),
    .buffer_data      (buffer_data),
    .find_average     (find_average),
    .full_buffer_flag (full_buffer_flag),
    .overrun          (overrun),
    .timeout_err      (timeout_err),
    .words_sent       (words_sent)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic present_fill();
    m_word = {m_fill[3], m_fill[2], m_fill[1], m_fill[0]};
    m_fill.delete();
    m_pres = 1'b1;
    m_age  = 0;
  endtask

  function automatic logic dn_at(input int delay);
    return m_pres && (m_age == delay);
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic dn, input logic clr,
                      input logic rst);
    logic was_empty;
    sample_valid = v;
    sample_data  = d;
    average_done = dn;
    clear_flags  = clr;
    reset        = rst;
    if (rst) begin
      m_fill.delete();
      m_pres = 1'b0;
      m_rel  = 1'b0;
      m_age  = 0;
      m_sent = '0;
      m_ovr  = 1'b0;
      m_tmo  = 1'b0;
    end else begin
      was_empty = !m_pres && !m_rel;
      if (clr) begin
        m_ovr = 1'b0;
        m_tmo = 1'b0;
      end
      if (m_pres) begin
        m_age++;
        if (dn) begin
          m_sent++;
          m_pres = 1'b0;
          m_rel  = 1'b1;
        end else if (m_age == Tmo) begin
          m_tmo  = 1'b1;
          m_pres = 1'b0;
          m_rel  = 1'b1;
        end
      end else begin
        m_rel = 1'b0;
        if (m_fill.size() == 4) present_fill();
      end
      if (v) begin
        if (m_fill.size() == 4) begin
          m_ovr = 1'b1;
        end else begin
          m_fill.push_back(d);
          if (m_fill.size() == 4 && was_empty) present_fill();
        end
      end
    end
    @(posedge clk_2);
    #1;
    chk("find_average", find_average, m_pres);
    chk("full_buffer_flag", full_buffer_flag, m_pres);
    chk("overrun", overrun, m_ovr);
    chk("timeout_err", timeout_err, m_tmo);
    chk("words_sent", words_sent, m_sent);
    if (m_pres) chk("buffer_data", buffer_data, m_word);
    if (rst) chk("reset_buffer_data", buffer_data, 32'h0);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input int delay, input logic clr);
    step(v, d, dn_at(delay), clr, 1'b0);
  endtask

  initial begin
    logic [7:0] avg;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Single word, done one cycle after find_average.
    drive(1'b1, 8'h10, 1, 1'b0);
    drive(1'b1, 8'h20, 1, 1'b0);
    drive(1'b1, 8'h30, 1, 1'b0);
    drive(1'b1, 8'h40, 1, 1'b0);
    chk("t1_word", buffer_data, 32'h40302010);
    chk("t1_find", find_average, 1'b1);
    avg = 8'((10'(buffer_data[7:0]) + 10'(buffer_data[15:8]) + 10'(buffer_data[23:16])
              + 10'(buffer_data[31:24])) >> 2);
    chk("t1_avg", avg, 8'h28);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1, 1'b0);
    chk("t1_sent", words_sent, 16'd1);

    // Two words back to back, done delayed 10 cycles.
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 10, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b0, 8'h00, 10, 1'b0);
    chk("t2_sent", words_sent, 16'd3);
    chk("t2_no_overrun", overrun, 1'b0);

    // Nine samples with done withheld, then clear.
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h50 + i), -1, 1'b0);
    chk("t3_overrun", overrun, 1'b1);
    drive(1'b0, 8'h00, -1, 1'b1);
    chk("t3_cleared", overrun, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 0, 1'b0);

    // Timeout with no done.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i), -1, 1'b0);
    for (int i = 0; i < Tmo + 3; i++) drive(1'b0, 8'h00, -1, 1'b0);
    chk("t4_timeout", timeout_err, 1'b1);
    chk("t4_idle", find_average, 1'b0);
    drive(1'b0, 8'h00, -1, 1'b1);

    // Reset mid-PRESENT with two bytes in the fill.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h70 + i), -1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hAA, -1, 1'b0);
    drive(1'b1, 8'hBB, -1, 1'b0);
    drive(1'b1, 8'hCC, -1, 1'b0);
    drive(1'b1, 8'hDD, -1, 1'b0);
    chk("t5_word", buffer_data, 32'hDDCCBBAA);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 0, 1'b0);

    // average_done while EMPTY is ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t6_sent", words_sent, 16'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) != 0, 8'($urandom), m_pres && ($urandom_range(0, 9) == 0),
           $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
